// File: rtl/crc_stream.sv
// Serial MSB-first CRC engine with generate and check modes.
// Check mode runs the appended checksum through the register and flags a non-zero residue.
module crc_stream #(
  parameter int               CRC_W = 15,
  parameter logic [CRC_W-1:0] POLY  = 15'h4599,
  parameter logic [CRC_W-1:0] INIT  = '0,
  parameter int               CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             bit_last,
  output logic             busy,
  output logic [CRC_W-1:0] crc_out,
  output logic             done,
  output logic             crc_err,
  output logic [CNT_W-1:0] bit_count
);

  localparam int              CHK_W    = $clog2(CRC_W + 1);
  localparam logic [CHK_W-1:0] CHK_LAST = CHK_W'(CRC_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, CHKSUM, DONE} state_t;

  state_t           state_reg;
  logic [CRC_W-1:0] crc_reg;
  logic [CRC_W-1:0] crc_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CHK_W-1:0] chk_reg;
  logic             mode_reg;
  logic             done_reg;
  logic             err_reg;

  // One LFSR step for the bit currently presented on bit_in.
  always_comb begin
    crc_next = {crc_reg[CRC_W-2:0], 1'b0};
    if (bit_in ^ crc_reg[CRC_W-1]) begin
      crc_next = crc_next ^ POLY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      crc_reg   <= INIT;
      cnt_reg   <= '0;
      chk_reg   <= '0;
      mode_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !abort) begin
            crc_reg   <= INIT;
            cnt_reg   <= '0;
            mode_reg  <= mode;
            err_reg   <= 1'b0;
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (bit_valid) begin
            crc_reg <= crc_next;
            if (cnt_reg != '1) begin
              cnt_reg <= cnt_reg + 1'b1;
            end
            if (bit_last) begin
              if (mode_reg) begin
                chk_reg   <= '0;
                state_reg <= CHKSUM;
              end else begin
                err_reg   <= 1'b0;
                done_reg  <= 1'b1;
                state_reg <= DONE;
              end
            end
          end
        end
        CHKSUM: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (bit_valid) begin
            crc_reg <= crc_next;
            // The error flag is resolved from the residue left by the final checksum bit.
            if (chk_reg == CHK_LAST) begin
              err_reg   <= (crc_next != '0);
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              chk_reg <= chk_reg + 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_reg == DATA) || (state_reg == CHKSUM);
  assign crc_out   = crc_reg;
  assign done      = done_reg;
  assign crc_err   = err_reg;
  assign bit_count = cnt_reg;

endmodule
